// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline-control types: FSM state encodings,
// the canonical NOP and the control-bundle helpers.
package rv32_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUBBLE   = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } pipe_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic pc_en;
    logic de_en;
    logic exe_en;
    logic acc_en;
    logic wb_en;
    logic bubble;
    logic flush;
  } ctl_t;

  // Every stage advances (or holds) together, no bubble/flush.
  function automatic ctl_t ctl_all(input logic en);
    ctl_t c;
    c.pc_en  = en;
    c.de_en  = en;
    c.exe_en = en;
    c.acc_en = en;
    c.wb_en  = en;
    c.bubble = 1'b0;
    c.flush  = 1'b0;
    return c;
  endfunction

  // Load-use: freeze FE/DE, inject a NOP into EXE.
  function automatic ctl_t ctl_stall();
    ctl_t c;
    c        = ctl_all(1'b1);
    c.pc_en  = 1'b0;
    c.de_en  = 1'b0;
    c.bubble = 1'b1;
    return c;
  endfunction

  // Redirect: everything moves, wrong-path FE/DE squashed.
  function automatic ctl_t ctl_flush();
    ctl_t c;
    c       = ctl_all(1'b1);
    c.flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter with enable;
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         full;

  assign full = &cnt_q;

  // Next value: +1 when enabled and not yet saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !full) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: stalls,
// redirect flushes and data-memory wait handling.
module pipe_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req,
  input  logic        redirect_exe,
  input  logic        dmem_req_acc,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        de_en,
  output logic        exe_en,
  output logic        acc_en,
  output logic        wb_en,
  output logic        bubble_exe,
  output logic        flush_fe_de,
  output logic [1:0]  state,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] ST_INIT = 3'(STALL_CYCLES - 1);
  localparam logic [8:0] TO_LIM  = 9'(MEM_TIMEOUT);
  localparam logic       FL_MULTI = (FLUSH_CYCLES > 1);
  localparam logic       ST_MULTI = (STALL_CYCLES > 1);

  pipe_state_e state_q, state_d;
  logic [2:0]  bub_q, bub_d;
  logic [2:0]  fl_q, fl_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  ctl_t        ctl;

  logic        mem_hold;
  logic        run_eval;
  logic        mem_chk;
  logic [8:0]  wait_inc;

  assign mem_hold = dmem_req_acc && !dmem_ack;
  assign wait_inc = {1'b0, wait_q} + 9'd1;

  // Control outputs and next state from state and inputs.
  always_comb begin
    ctl      = ctl_all(1'b1);
    state_d  = state_q;
    bub_d    = bub_q;
    fl_d     = fl_q;
    wait_d   = wait_q;
    err_d    = err_q;
    run_eval = 1'b0;
    mem_chk  = 1'b1;

    unique case (state_q)
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          // completion cycle acts as a plain RUN cycle
          run_eval = 1'b1;
          mem_chk  = 1'b0;
          wait_d   = '0;
        end else if (wait_inc == TO_LIM) begin
          // give up: flag and let the pipe move on
          ctl     = ctl_all(1'b1);
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = ST_RUN;
        end else begin
          ctl    = ctl_all(1'b0);
          wait_d = wait_inc[7:0];
        end
      end
      ST_FLUSH: begin
        if (mem_hold || redirect_exe) begin
          run_eval = 1'b1;
        end else begin
          ctl = ctl_flush();
          if (fl_q <= 3'd1) begin
            fl_d    = '0;
            state_d = ST_RUN;
          end else begin
            fl_d = fl_q - 3'd1;
          end
        end
      end
      ST_BUBBLE: begin
        if (mem_hold || redirect_exe) begin
          run_eval = 1'b1;
        end else begin
          ctl = ctl_stall();
          if (bub_q <= 3'd1) begin
            bub_d   = '0;
            state_d = ST_RUN;
          end else begin
            bub_d = bub_q - 3'd1;
          end
        end
      end
      default: begin
        run_eval = 1'b1;
      end
    endcase

    // Shared RUN decision: memory > redirect > stall.
    if (run_eval) begin
      if (mem_chk && mem_hold) begin
        ctl     = ctl_all(1'b0);
        wait_d  = '0;
        fl_d    = '0;
        bub_d   = '0;
        state_d = ST_MEM_WAIT;
      end else if (redirect_exe) begin
        ctl     = ctl_flush();
        fl_d    = FL_INIT;
        bub_d   = '0;
        state_d = FL_MULTI ? ST_FLUSH : ST_RUN;
      end else if (stall_req) begin
        ctl     = ctl_stall();
        bub_d   = ST_INIT;
        fl_d    = '0;
        state_d = ST_MULTI ? ST_BUBBLE : ST_RUN;
      end else begin
        ctl     = ctl_all(1'b1);
        state_d = ST_RUN;
      end
    end
  end

  // State, sequencing counters and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      bub_q   <= '0;
      fl_q    <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      fl_q    <= fl_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Everything quiet while reset is held.
  assign pc_en       = !rst && ctl.pc_en;
  assign de_en       = !rst && ctl.de_en;
  assign exe_en      = !rst && ctl.exe_en;
  assign acc_en      = !rst && ctl.acc_en;
  assign wb_en       = !rst && ctl.wb_en;
  assign bubble_exe  = !rst && ctl.bubble;
  assign flush_fe_de = !rst && ctl.flush;
  assign state       = state_q;
  assign mem_err     = err_q;

  sat_counter #(
    .W (32)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (!pc_en),
    .cnt_o (stall_cnt)
  );

endmodule
